// File: rtl/counter_checker.sv
// In-line checker for a mod-MOD up/down counter: predicts the next value, compares it one cycle later, keeps stats.
// Optional coverage counters (wrap_up/wrap_down/load) are built when COUNTER_CHK_COVER_EN is defined.
module counter_checker #(
  parameter int WIDTH       = 4,
  parameter int MOD         = 12,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               chk_en,
  input  logic               clr,
  input  logic               dut_reset,
  input  logic               load,
  input  logic               mode,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [WIDTH-1:0]   data_out,
  output logic               match,
  output logic               mismatch,
  output logic               illegal_load,
  output logic               synced,
  output logic [WIDTH-1:0]   expected,
  output logic [CNT_W-1:0]   check_count,
  output logic [CNT_W-1:0]   err_count,
  output logic [2*WIDTH-1:0] first_err
`ifdef COUNTER_CHK_COVER_EN
  ,
  output logic [CNT_W-1:0]   wrap_up_count,
  output logic [CNT_W-1:0]   wrap_down_count,
  output logic [CNT_W-1:0]   load_count
`endif
);

  typedef enum logic [1:0] {UNSYNC, TRACK, FAIL} state_t;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t           state, eff;
  logic             stale;
  logic [WIDTH-1:0] pred;
  logic             ld_ok, ld_bad, hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  assign ld_bad = load & ~dut_reset & (data_in > LAST);
  assign ld_ok  = load & ~dut_reset & (data_in <= LAST);
  assign hit    = (data_out == expected);
  assign synced = (state == TRACK);
  // A disabled window leaves the counter's history unknown, so tracking restarts.
  assign eff    = (stale && state == TRACK) ? UNSYNC : state;

  always_comb begin
    pred = expected;
    if (dut_reset)   pred = '0;
    else if (load)   pred = data_in;
    else if (mode)   pred = (expected == LAST) ? '0 : expected + 1'b1;
    else             pred = (expected == '0) ? LAST : expected - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= UNSYNC;
      stale           <= 1'b0;
      match           <= 1'b0;
      mismatch        <= 1'b0;
      illegal_load    <= 1'b0;
      expected        <= '0;
      check_count     <= '0;
      err_count       <= '0;
      first_err       <= '0;
`ifdef COUNTER_CHK_COVER_EN
      wrap_up_count   <= '0;
      wrap_down_count <= '0;
      load_count      <= '0;
`endif
    end else begin
      match        <= 1'b0;
      mismatch     <= 1'b0;
      illegal_load <= 1'b0;
      if (!chk_en) begin
        stale <= 1'b1;
      end else begin
        stale <= 1'b0;
        case (eff)
          UNSYNC: begin
            state <= UNSYNC;
            if (ld_bad) illegal_load <= 1'b1;
            else if (dut_reset || ld_ok) begin
              state    <= TRACK;
              expected <= pred;
            end
          end
          TRACK: begin
            if (ld_bad) begin
              illegal_load <= 1'b1;
              state        <= UNSYNC;
            end else begin
              expected <= pred;
              if (!clr) begin
                check_count <= sat_inc(check_count);
                match       <= hit;
                mismatch    <= ~hit;
                if (!hit) begin
                  err_count <= sat_inc(err_count);
                  if (err_count == '0) first_err <= {expected, data_out};
                  if (STOP_ON_ERR != 0) state <= FAIL;
                end
              end
            end
          end
          default: ;
        endcase
`ifdef COUNTER_CHK_COVER_EN
        if (eff == TRACK && !dut_reset && !load) begin
          if (mode && expected == LAST)   wrap_up_count   <= sat_inc(wrap_up_count);
          if (!mode && expected == '0)    wrap_down_count <= sat_inc(wrap_down_count);
        end
        if (ld_ok && eff != FAIL) load_count <= sat_inc(load_count);
`endif
      end
      // clr overrides any same-cycle statistic update above.
      if (clr) begin
        check_count <= '0;
        err_count   <= '0;
        first_err   <= '0;
`ifdef COUNTER_CHK_COVER_EN
        wrap_up_count   <= '0;
        wrap_down_count <= '0;
        load_count      <= '0;
`endif
        if (state == FAIL) state <= UNSYNC;
      end
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: a mod-12 counter model drives data_out; a scoreboard queue holds expected pulses.
module tb_counter_checker;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b1, clr = 1'b0, dut_reset = 1'b0, load = 1'b0, mode = 1'b0;
  logic [3:0] data_in = '0, data_out = '0;
  logic match, mismatch, illegal_load, synced;
  logic [3:0] expected;
  logic [15:0] check_count, err_count;
  logic [7:0] first_err;
  logic s_match, s_mismatch, s_illegal_load, s_synced;
  logic [3:0] s_expected;
  logic [15:0] s_check_count, s_err_count;
  logic [7:0] s_first_err;
`ifdef COUNTER_CHK_COVER_EN
  logic [15:0] wrap_up_count, wrap_down_count, load_count;
  logic [15:0] s_wrap_up_count, s_wrap_down_count, s_load_count;
`endif

  int checks = 0, errors = 0;
  int cnt = 0;
  bit [1:0] sbq[$];

  always #5 clock = ~clock;

  counter_checker u_dut (
    .clock(clock), .reset(reset), .chk_en(chk_en), .clr(clr), .dut_reset(dut_reset),
    .load(load), .mode(mode), .data_in(data_in), .data_out(data_out),
    .match(match), .mismatch(mismatch), .illegal_load(illegal_load), .synced(synced),
    .expected(expected), .check_count(check_count), .err_count(err_count), .first_err(first_err)
`ifdef COUNTER_CHK_COVER_EN
    , .wrap_up_count(wrap_up_count), .wrap_down_count(wrap_down_count), .load_count(load_count)
`endif
  );

  counter_checker #(.STOP_ON_ERR(1)) u_stop (
    .clock(clock), .reset(reset), .chk_en(chk_en), .clr(clr), .dut_reset(dut_reset),
    .load(load), .mode(mode), .data_in(data_in), .data_out(data_out),
    .match(s_match), .mismatch(s_mismatch), .illegal_load(s_illegal_load), .synced(s_synced),
    .expected(s_expected), .check_count(s_check_count), .err_count(s_err_count), .first_err(s_first_err)
`ifdef COUNTER_CHK_COVER_EN
    , .wrap_up_count(s_wrap_up_count), .wrap_down_count(s_wrap_down_count), .load_count(s_load_count)
`endif
  );

  // One counter cycle: drive controls and data_out (counter value, or a forced value),
  // push the expected {match,mismatch} pair, advance the counter model, then pop and compare.
  task automatic drive(input bit dr, input bit ld, input bit md, input int din,
                       input bit frc, input int fv, input bit em, input bit emm);
    bit [1:0] pe;
    @(negedge clock);
    dut_reset = dr; load = ld; mode = md; data_in = din[3:0];
    data_out = frc ? fv[3:0] : cnt[3:0];
    sbq.push_back({em, emm});
    @(posedge clock);
    if (dr)      cnt = 0;
    else if (ld) cnt = din & 15;
    else if (md) cnt = (cnt == 11) ? 0 : cnt + 1;
    else         cnt = (cnt == 0) ? 11 : cnt - 1;
    #1;
    if (sbq.size() > 0) begin
      pe = sbq.pop_front();
      checks++;
      if ({match, mismatch} !== pe) begin
        errors++;
        $display("FAIL pulses got %b want %b at %0t", {match, mismatch}, pe, $time);
      end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({match, mismatch, illegal_load, synced} !== 4'b0 || expected !== 4'd0) begin
      errors++; $display("FAIL reset_flags got %b/%0d want 0", {match, mismatch, illegal_load, synced}, expected);
    end
    checks++;
    if (check_count !== 16'd0 || err_count !== 16'd0 || first_err !== 8'd0) begin
      errors++; $display("FAIL reset_stats got %0d/%0d/%h want 0", check_count, err_count, first_err);
    end
    @(negedge clock) reset = 1'b1;
  endtask

  task automatic test_count_up();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, 1, 0, 0, 0, 1, 0);
      checks++;
      if (expected !== cnt[3:0]) begin
        errors++; $display("FAIL up_expected step %0d got %0d want %0d", i, expected, cnt);
      end
    end
    checks++;
    if (synced !== 1'b1 || check_count !== 16'd14 || err_count !== 16'd0) begin
      errors++; $display("FAIL up_stats got %b/%0d/%0d want 1/14/0", synced, check_count, err_count);
    end
`ifdef COUNTER_CHK_COVER_EN
    checks++;
    if (wrap_up_count !== 16'd1) begin
      errors++; $display("FAIL wrap_up got %0d want 1", wrap_up_count);
    end
`endif
  endtask

  task automatic test_wrap_down();
    drive(0, 1, 0, 0, 0, 0, 1, 0);
    checks++;
    if (expected !== 4'd0) begin errors++; $display("FAIL load0 got %0d want 0", expected); end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (expected !== 4'd11) begin errors++; $display("FAIL down_wrap got %0d want 11", expected); end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (expected !== 4'd10) begin errors++; $display("FAIL down got %0d want 10", expected); end
`ifdef COUNTER_CHK_COVER_EN
    checks++;
    if (wrap_down_count !== 16'd1 || load_count !== 16'd1) begin
      errors++; $display("FAIL cover got %0d/%0d want 1/1", wrap_down_count, load_count);
    end
`endif
  endtask

  task automatic test_mismatch();
    repeat (3) drive(0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (expected !== 4'd7) begin errors++; $display("FAIL pre_mm got %0d want 7", expected); end
    drive(0, 0, 1, 0, 1, 5, 0, 1);
    checks++;
    if (err_count !== 16'd1 || first_err !== 8'h75 || check_count !== 16'd21) begin
      errors++; $display("FAIL mm_stats got %0d/%h/%0d want 1/75/21", err_count, first_err, check_count);
    end
    checks++;
    if (synced !== 1'b1 || s_synced !== 1'b0 || s_mismatch !== 1'b1) begin
      errors++; $display("FAIL mm_sync got %b/%b/%b want 1/0/1", synced, s_synced, s_mismatch);
    end
    drive(0, 0, 1, 0, 0, 0, 1, 0);
    checks++;
    if (s_err_count !== 16'd1 || s_check_count !== 16'd21 || s_match !== 1'b0) begin
      errors++; $display("FAIL frozen got %0d/%0d/%b want 1/21/0", s_err_count, s_check_count, s_match);
    end
  endtask

  task automatic test_illegal_load();
    drive(0, 1, 0, 13, 0, 0, 0, 0);
    checks++;
    if (illegal_load !== 1'b1 || synced !== 1'b0 || check_count !== 16'd22) begin
      errors++; $display("FAIL illegal got %b/%b/%0d want 1/0/22", illegal_load, synced, check_count);
    end
    checks++;
    if (s_illegal_load !== 1'b0) begin errors++; $display("FAIL illegal_frozen got 1 want 0"); end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (illegal_load !== 1'b0 || synced !== 1'b1 || expected !== 4'd0) begin
      errors++; $display("FAIL resync got %b/%b/%0d want 0/1/0", illegal_load, synced, expected);
    end
    drive(0, 0, 1, 0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_load();
    drive(1, 1, 0, 9, 0, 0, 1, 0);
    checks++;
    if (illegal_load !== 1'b0 || expected !== 4'd0) begin
      errors++; $display("FAIL rst_load got %b/%0d want 0/0", illegal_load, expected);
    end
    drive(0, 0, 1, 0, 0, 0, 1, 0);
    checks++;
    if (check_count !== 16'd25) begin errors++; $display("FAIL rl_count got %0d want 25", check_count); end
  endtask

  task automatic test_disable();
    logic [3:0] hold;
    hold = expected;
    chk_en = 1'b0;
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (expected !== hold || check_count !== 16'd25) begin
      errors++; $display("FAIL dis_hold got %0d/%0d want %0d/25", expected, check_count, hold);
    end
    chk_en = 1'b1;
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (synced !== 1'b0) begin errors++; $display("FAIL reenable got synced 1 want 0"); end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_saturate_clr();
    for (int i = 0; i < 70000; i++) drive(0, 0, 1, 0, 1, (cnt + 1) % 12, 0, 1);
    checks++;
    if (err_count !== 16'hFFFF || check_count !== 16'hFFFF || first_err !== 8'h75) begin
      errors++; $display("FAIL sat got %0d/%0d/%h want 65535/65535/75", err_count, check_count, first_err);
    end
    clr = 1'b1;
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    clr = 1'b0;
    checks++;
    if (err_count !== 16'd0 || check_count !== 16'd0 || first_err !== 8'd0) begin
      errors++; $display("FAIL clr got %0d/%0d/%h want 0", err_count, check_count, first_err);
    end
    checks++;
    if (s_err_count !== 16'd0 || s_synced !== 1'b0) begin
      errors++; $display("FAIL clr_fail got %0d/%b want 0/0", s_err_count, s_synced);
    end
`ifdef COUNTER_CHK_COVER_EN
    checks++;
    if (wrap_up_count !== 16'd0 || load_count !== 16'd0) begin
      errors++; $display("FAIL clr_cover got %0d/%0d want 0", wrap_up_count, load_count);
    end
`endif
    drive(0, 0, 1, 0, 0, 0, 1, 0);
    checks++;
    if (check_count !== 16'd1) begin errors++; $display("FAIL post_clr got %0d want 1", check_count); end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 1, 0, 0, 0, 1, 0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (synced !== 1'b0 || expected !== 4'd0 || check_count !== 16'd0 || match !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %b/%0d/%0d/%b want 0", synced, expected, check_count, match);
    end
    @(negedge clock) reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_down();
    test_mismatch();
    test_illegal_load();
    test_reset_load();
    test_disable();
    test_saturate_clr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Synthesizable in-line checker that sits on the far end of the mod-12 counter's control/data interface.
- Observes the control inputs driven to the counter (dut_reset, load, mode, data_in) and the returned data_out.
- Predicts the counter's next value every cycle, compares one cycle later, and reports match/mismatch pulses plus saturating statistics.
- Intended for emulation/FPGA builds and as a self-check monitor in the counter bench.

Parameters:
- WIDTH, 4, width of data_in/data_out
- MOD, 12, counter modulus; legal values 0..MOD-1
- CNT_W, 16, width of statistics counters
- STOP_ON_ERR, 0, 1 = first mismatch freezes checker in FAIL state

Ports:
- clock  in  1  checker clock, same clock as the counter
- reset  in  1  asynchronous active-low reset of the checker
- chk_en  in  1  1 = checking enabled; 0 = hold state, no compares
- clr  in  1  synchronous clear of statistics and FAIL state
- dut_reset  in  1  counter's synchronous active-high reset as driven to it
- load  in  1  counter load strobe
- mode  in  1  counter direction: 1 = up, 0 = down
- data_in  in  WIDTH  counter load value
- data_out  in  WIDTH  counter output under check
- match  out  1  one-cycle pulse: compare passed
- mismatch  out  1  one-cycle pulse: compare failed
- illegal_load  out  1  one-cycle pulse: load with data_in >= MOD
- synced  out  1  1 = prediction valid (state TRACK)
- expected  out  WIDTH  current predicted value
- check_count  out  CNT_W  number of compares performed, saturating
- err_count  out  CNT_W  number of mismatches, saturating
- first_err  out  2*WIDTH  {expected, data_out} captured at the first mismatch

Behaviour:
- Reset (reset low, async): state UNSYNC. All outputs 0.
- Sampling: at each rising clock edge with chk_en=1, the checker samples the counter inputs and computes pred.
- Prediction priority:
  - dut_reset=1: pred = 0.
  - Else load=1: pred = data_in.
  - Else mode=1: pred = (expected == MOD-1) ? 0 : expected+1.
  - Else: pred = (expected == 0) ? MOD-1 : expected-1.
- Compare latency: the prediction made at edge N is compared against data_out sampled at edge N+1. match/mismatch assert in the cycle after edge N+1, are mutually exclusive, and last one cycle.
- States:
  - UNSYNC: no compares. dut_reset, or load with data_in < MOD, moves to TRACK with expected = pred.
  - TRACK: compare every enabled cycle.
    - Pass: pulse match.
    - Fail: pulse mismatch, increment err_count, capture first_err if err_count was 0.
    - Either way, check_count increments and expected = pred. A mismatch does not resync.
    - If STOP_ON_ERR=1, a mismatch moves to FAIL.
  - FAIL: outputs frozen, no compares. Exit only via clr (to UNSYNC) or reset.
- Illegal load (load=1, dut_reset=0, data_in >= MOD): pulse illegal_load and go to UNSYNC from any state except FAIL. The pending compare for that cycle is discarded.
- Simultaneous dut_reset and load: dut_reset wins, pred = 0, no illegal_load flag.
- chk_en=0: state, expected, and counters hold, and the pending compare is dropped. On re-enable the state drops to UNSYNC, because counter activity while disabled is unknown.
- clr:
  - Zeroes check_count, err_count, and first_err; FAIL goes to UNSYNC.
  - clr takes priority over a same-cycle compare: that compare is not counted.
- Counters saturate at 2^CNT_W-1. No wrap.
- Reset mid-operation: immediate return to the reset values. Any in-flight compare is lost.

Optional Feature:
- Macro COUNTER_CHK_COVER_EN.
- Defined: adds outputs wrap_up_count, wrap_down_count, and load_count (each CNT_W bits, saturating, cleared by clr).
  - wrap_up_count counts predicted transitions MOD-1 -> 0 while mode=1.
  - wrap_down_count counts predicted transitions 0 -> MOD-1 while mode=0.
  - load_count counts legal loads.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Hold reset low, then release with dut_reset=1 for 1 cycle, then mode=1 for 14 cycles -> synced=1; 14 match pulses; expected sequence 1..11,0,1,2; err_count=0; check_count=14.
- load=1 with data_in=0, then mode=0 for 2 cycles -> expected 0 then 11 then 10; no mismatch; wrap_down_count=1 if COUNTER_CHK_COVER_EN is defined.
- Force data_out=5 while expected=7 -> exactly one mismatch pulse; err_count=1; first_err={7,5}; with STOP_ON_ERR=1 the checker enters FAIL and synced=0.
- load=1 with data_in=13 -> illegal_load pulse; synced=0; no compare; next dut_reset resyncs to 0.
- dut_reset=1 and load=1 with data_in=9 in the same cycle -> pred=0; illegal_load=0; next data_out=0 gives a match.
- Drive 70000 mismatches with CNT_W=16 -> err_count saturates at 65535; clr drives err_count and check_count to 0 on the next cycle.
